// File: rtl/bcd_elapsed_counter_pkg.sv
// Shared constants and the per-digit rollover limit for the BCD elapsed counter.
package bcd_elapsed_counter_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX_DEC = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_SIX = 4'd5;

  // Control input bit positions in the synchronizer vectors.
  localparam int CTL_SS  = 0;
  localparam int CTL_CLR = 1;
  localparam int CTL_LAP = 2;
  localparam int CTL_N   = 3;

  // Tens-of-seconds and tens-of-minutes count 0..5 when MM:SS rollover is on.
  function automatic logic [BCD_W-1:0] digit_limit(input int idx, input bit roll_sixty);
    return (roll_sixty && (idx == 1 || idx == 3)) ? DIGIT_MAX_SIX : DIGIT_MAX_DEC;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: increments on inc, wraps to 0 past its limit, synchronous clear.
module bcd_digit
  import bcd_elapsed_counter_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [BCD_W-1:0] limit,
  output logic [BCD_W-1:0] q,
  output logic             at_max
);
  assign at_max = (q == limit);

  always_ff @(posedge clock) begin
    if (!rst)      q <= '0;
    else if (clr)  q <= '0;
    else if (inc)  q <= at_max ? '0 : q + 4'd1;
  end
endmodule

// File: rtl/bcd_elapsed_counter.sv
// Prescaled start/stop BCD elapsed-time counter with lap hold, clear and sticky overflow.
module bcd_elapsed_counter
  import bcd_elapsed_counter_pkg::*;
#(
  parameter int NUMCELLS   = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int ROLL_SIXTY = 1
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      start_stop,
  input  logic                      clear,
  input  logic                      lap,
  output logic [BCD_W*NUMCELLS-1:0] elapsed,
  output logic                      running,
  output logic                      lap_active,
  output logic                      overflow,
  output logic                      tick
);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [CTL_N-1:0] raw, sync_q, dly_q, arm_q, ctl_edge;
  logic             ss_e, clr_e, lap_e;
  logic [PRE_W-1:0] pre;
  logic [NUMCELLS-1:0][BCD_W-1:0] q, nxt;
  logic [NUMCELLS-1:0] at_max, inc;
  logic             wrap, lap_nxt;

  assign raw = {lap, clear, start_stop};

  // arm_q stays low until an input is seen low after reset, so a level held
  // high across reset release never produces a spurious edge.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= raw;
      dly_q  <= sync_q;
      arm_q  <= arm_q | ~raw;
    end
  end

  assign ctl_edge = sync_q & ~dly_q & arm_q;
  assign ss_e     = ctl_edge[CTL_SS];
  assign clr_e    = ctl_edge[CTL_CLR];
  assign lap_e    = ctl_edge[CTL_LAP];

  assign tick = running && (pre == PRE_LAST);

  for (genvar g = 0; g < NUMCELLS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign inc[g] = tick;
    end else begin : g_upper
      assign inc[g] = tick & (&at_max[g-1:0]);
    end

    bcd_digit u_digit (
      .clock  (clock),
      .rst    (rst),
      .clr    (clr_e),
      .inc    (inc[g]),
      .limit  (digit_limit(g, ROLL_SIXTY != 0)),
      .q      (q[g]),
      .at_max (at_max[g])
    );

    // Next live value, so elapsed tracks the count without a cycle of lag.
    assign nxt[g] = clr_e ? '0 : (inc[g] ? (at_max[g] ? '0 : q[g] + 4'd1) : q[g]);
  end

  assign wrap    = tick & (&at_max);
  assign lap_nxt = clr_e ? 1'b0 : (lap_active ^ lap_e);

  always_ff @(posedge clock) begin
    if (!rst) begin
      pre        <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      elapsed    <= '0;
    end else begin
      if (clr_e)        pre <= '0;
      else if (running) pre <= tick ? '0 : pre + PRE_W'(1);

      if (ss_e) running <= ~running;

      if (clr_e)     overflow <= 1'b0;
      else if (wrap) overflow <= 1'b1;

      lap_active <= lap_nxt;
      if (!lap_nxt) elapsed <= nxt;
    end
  end
endmodule

// File: tb/tb_bcd_elapsed_counter.sv
// Randomized and directed check of bcd_elapsed_counter against a seconds-based MM:SS model.
module tb_bcd_elapsed_counter;
  localparam int NUMCELLS = 4;
  localparam int TICK_DIV = 4;
  localparam int FULL     = 3600;

  logic clock = 1'b0;
  logic rst = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [4*NUMCELLS-1:0] elapsed;
  logic running, lap_active, overflow, tick;

  always #5 clock = ~clock;

  bcd_elapsed_counter #(.NUMCELLS(NUMCELLS), .TICK_DIV(TICK_DIV), .ROLL_SIXTY(1)) dut (
    .clock      (clock),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .elapsed    (elapsed),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .tick       (tick)
  );

  int n_vec = 0, n_bad = 0;

  // Model: count held as plain seconds 0..3599, shown value converted to MM:SS BCD.
  bit [2:0] m_sync, m_dly, m_arm;
  bit       m_run, m_ovf, m_lap;
  int       m_pre, m_v, m_el, n_ticks;

  function automatic logic [15:0] to_bcd(input int v);
    int mm, ss;
    mm = v / 60;
    ss = v % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit l);
    bit [2:0] raw, e;
    bit       t;
    @(negedge clock);
    rst = r; start_stop = s; clear = c; lap = l;
    @(posedge clock);
    raw = {l, c, s};
    if (!r) begin
      m_sync = '0; m_dly = '0; m_arm = '0;
      m_run = 0; m_ovf = 0; m_lap = 0;
      m_pre = 0; m_v = 0; m_el = 0;
    end else begin
      e = m_sync & ~m_dly & m_arm;
      t = m_run && (m_pre == TICK_DIV - 1);
      if (e[1]) begin
        m_pre = 0; m_v = 0; m_ovf = 0;
      end else begin
        if (t) begin
          n_ticks++;
          if (m_v == FULL - 1) m_ovf = 1;
          m_v = (m_v + 1) % FULL;
        end
        if (m_run) m_pre = t ? 0 : m_pre + 1;
      end
      if (e[0]) m_run = !m_run;
      m_lap = e[1] ? 1'b0 : (m_lap ^ e[2]);
      if (e[1])        m_el = 0;
      else if (!m_lap) m_el = m_v;
      m_dly = m_sync;
      m_sync = raw;
      m_arm = m_arm | ~raw;
    end
    #1;
    chk("elapsed", 32'(elapsed), 32'(to_bcd(m_el)));
    chk("running", 32'(running), 32'(m_run));
    chk("lap_active", 32'(lap_active), 32'(m_lap));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tick", 32'(tick), 32'(m_run && (m_pre == TICK_DIV - 1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic run_ticks(input int n);
    int tgt, b;
    tgt = n_ticks + n;
    b = 0;
    while (n_ticks < tgt && b < n * TICK_DIV + 20) begin
      step(1, 0, 0, 0);
      b++;
    end
    if (n_ticks < tgt) chk("tick_budget", 32'(n_ticks), 32'(tgt));
  endtask

  task automatic pulse(input bit s, input bit c, input bit l);
    step(1, s, c, l);
    step(1, 0, 0, 0);
  endtask

  initial begin
    n_ticks = 0;
    repeat (3) step(0, 0, 0, 0);
    chk("rst_elapsed", 32'(elapsed), 32'h0);
    chk("rst_running", 32'(running), 32'h0);

    // start: first sampled at edge N, takes effect at N+1
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("run_not_yet", 32'(running), 32'h0);
    step(1, 0, 0, 0);
    chk("run_on", 32'(running), 32'h1);
    run_ticks(1);
    chk("cnt_1", 32'(elapsed), 32'h0001);
    run_ticks(1);
    chk("cnt_2", 32'(elapsed), 32'h0002);

    // pause holds value and prescaler
    pulse(1, 0, 0);
    chk("paused", 32'(running), 32'h0);
    idle(12);
    chk("pause_hold", 32'(elapsed), 32'h0002);
    pulse(1, 0, 0);

    run_ticks(57);
    chk("cnt_0059", 32'(elapsed), 32'h0059);
    run_ticks(1);
    chk("cnt_0100", 32'(elapsed), 32'h0100);
    run_ticks(539);
    chk("cnt_0959", 32'(elapsed), 32'h0959);
    run_ticks(1);
    chk("cnt_1000", 32'(elapsed), 32'h1000);
    run_ticks(2999);
    chk("cnt_5959", 32'(elapsed), 32'h5959);
    chk("no_ovf_yet", 32'(overflow), 32'h0);
    run_ticks(1);
    chk("wrap_zero", 32'(elapsed), 32'h0000);
    chk("wrap_ovf", 32'(overflow), 32'h1);
    chk("wrap_run", 32'(running), 32'h1);
    run_ticks(3);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    pulse(0, 1, 0);
    chk("ovf_cleared", 32'(overflow), 32'h0);
    chk("clr_zero", 32'(elapsed), 32'h0000);

    // clear coincident with tick at 0007
    run_ticks(7);
    chk("cnt_0007", 32'(elapsed), 32'h0007);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("pre_tick", 32'(tick), 32'h1);
    step(1, 0, 0, 0);
    chk("clr_beats_tick", 32'(elapsed), 32'h0000);
    chk("clr_keeps_run", 32'(running), 32'h1);
    idle(3);
    chk("clr_no_early", 32'(elapsed), 32'h0000);
    step(1, 0, 0, 0);
    chk("clr_next_inc", 32'(elapsed), 32'h0001);

    // lap hold
    run_ticks(11);
    pulse(0, 0, 1);
    chk("lap_on", 32'(lap_active), 32'h1);
    run_ticks(10);
    chk("lap_hold", 32'(elapsed), 32'h0012);
    pulse(0, 0, 1);
    chk("lap_off", 32'(lap_active), 32'h0);
    chk("lap_release", 32'(elapsed), 32'h0022);

    // reset mid-count with lap active, start_stop held across release
    run_ticks(162);
    chk("cnt_0304", 32'(elapsed), 32'h0304);
    pulse(0, 0, 1);
    step(0, 1, 0, 0);
    chk("rst_mid_el", 32'(elapsed), 32'h0);
    chk("rst_mid_lap", 32'(lap_active), 32'h0);
    chk("rst_mid_run", 32'(running), 32'h0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    chk("held_no_toggle", 32'(running), 32'h0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("rearmed_toggle", 32'(running), 32'h1);

    // random control traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
